// File: rtl/taxi_stat_pkg.sv
// Shared definitions for the MAC statistics accumulator: stat beat field widths
// and the op codes carried down the read-modify-write pipeline.
package taxi_stat_pkg;

    localparam int STAT_INC_W = 16;
    localparam int STAT_ID_W  = 8;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_UPD,
        OP_RD,
        OP_RDCLR,
        OP_INIT
    } op_t;

    function automatic logic op_writes(input op_t op);
        return op inside {OP_UPD, OP_RDCLR, OP_INIT};
    endfunction

    function automatic logic op_reads(input op_t op);
        return op inside {OP_RD, OP_RDCLR};
    endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// Minimal AXI-stream interface: data, id, user and handshake only
// (the statistics stream carries no keep and no last).
interface taxi_axis_if #(
    parameter int DATA_W = 8,
    parameter int ID_W   = 8,
    parameter int USER_W = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic [ID_W-1:0]   tid;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tready;

    modport src (output tdata, tid, tuser, tvalid, input tready);
    modport snk (input tdata, tid, tuser, tvalid, output tready);
endinterface

// File: rtl/taxi_stat_ram.sv
// Simple dual-port counter RAM: one write port, one read port with a
// registered output; read-during-write to the same address returns old data.
module taxi_stat_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/taxi_eth_mac_stat_accum.sv
// Accumulates MAC statistic increments into per-ID wide counters in RAM and
// serves read / clear-on-read requests through the same RMW pipeline.
//
// state    | meaning
// ST_INIT  | sweeping zeros into the RAM, one address per cycle
// ST_DRAIN | last zero write still in flight
// ST_RUN   | sweep finished, accepting stat beats and read requests
module taxi_eth_mac_stat_accum
    import taxi_stat_pkg::*;
#(
    parameter int CNT_W        = 64,
    parameter int NUM_CNT      = 256,
    parameter int ID_BASE      = 0,
    parameter int CLR_ON_RD_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    taxi_axis_if.snk                   s_axis_stat,
    input  logic                       rd_req_valid,
    output logic                       rd_req_ready,
    input  logic [$clog2(NUM_CNT)-1:0] rd_req_addr,
    input  logic                       rd_req_clr,
    output logic                       rd_rsp_valid,
    output logic [CNT_W-1:0]           rd_rsp_data,
    output logic                       init_done
);

    localparam int ADDR_W = $clog2(NUM_CNT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CNT - 1);

    typedef enum logic [1:0] {ST_INIT, ST_DRAIN, ST_RUN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] init_addr;

    logic [STAT_ID_W-1:0]  s0_id;
    logic [31:0]           id_ext;
    logic                  id_in_range;
    logic [ADDR_W-1:0]     id_idx;
    op_t                   s0_op;
    logic [ADDR_W-1:0]     s0_addr;
    logic [STAT_INC_W-1:0] s0_inc;

    op_t                   s1_op;
    logic [ADDR_W-1:0]     s1_addr;
    logic [STAT_INC_W-1:0] s1_inc;
    logic [CNT_W-1:0]      ram_q;
    logic [CNT_W-1:0]      s1_old;
    logic [CNT_W-1:0]      s1_new;
    logic                  s1_wr;

    logic                  wb_valid;
    logic [ADDR_W-1:0]     wb_addr;
    logic [CNT_W-1:0]      wb_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            init_addr <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                init_addr <= init_addr + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:  if (init_addr == LAST_ADDR) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_INIT;
        endcase
    end

    assign init_done          = (state == ST_RUN);
    assign rd_req_ready       = init_done;
    assign s_axis_stat.tready = init_done && !rd_req_valid;

    // Offset arithmetic wraps IDs below ID_BASE to huge values, so one compare covers both ends.
    assign s0_id       = s_axis_stat.tid;
    assign id_ext      = 32'(s0_id);
    assign id_in_range = (id_ext - 32'(ID_BASE)) < 32'(NUM_CNT);
    assign id_idx      = ADDR_W'(id_ext - 32'(ID_BASE));

    always_comb begin
        s0_op   = OP_NOP;
        s0_addr = '0;
        s0_inc  = '0;
        if (state == ST_INIT) begin
            s0_op   = OP_INIT;
            s0_addr = init_addr;
        end else if (init_done && rd_req_valid) begin
            s0_op   = (rd_req_clr && (CLR_ON_RD_EN != 0)) ? OP_RDCLR : OP_RD;
            s0_addr = rd_req_addr;
        end else if (init_done && s_axis_stat.tvalid) begin
            s0_op   = (id_in_range && !s_axis_stat.tuser[0]) ? OP_UPD : OP_NOP;
            s0_addr = id_idx;
            s0_inc  = s_axis_stat.tdata;
        end
    end

    taxi_stat_ram #(
        .DATA_W (CNT_W),
        .DEPTH  (NUM_CNT),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (s1_wr),
        .wr_addr (s1_addr),
        .wr_data (s1_new),
        .rd_addr (s0_addr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_op   <= OP_NOP;
            s1_addr <= '0;
            s1_inc  <= '0;
        end else begin
            s1_op   <= s0_op;
            s1_addr <= s0_addr;
            s1_inc  <= s0_inc;
        end
    end

    // The RAM read for this op happened on the same edge as the previous op's
    // write, so that write is replayed from the write-back register instead.
    assign s1_old = (wb_valid && (wb_addr == s1_addr)) ? wb_data : ram_q;
    assign s1_wr  = op_writes(s1_op);

    always_comb begin
        s1_new = '0;
        if (s1_op == OP_UPD) begin
            s1_new = s1_old + CNT_W'(s1_inc);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            rd_rsp_valid <= 1'b0;
            rd_rsp_data  <= '0;
        end else begin
            wb_valid     <= s1_wr;
            wb_addr      <= s1_addr;
            wb_data      <= s1_new;
            rd_rsp_valid <= op_reads(s1_op);
            if (op_reads(s1_op)) begin
                rd_rsp_data <= s1_old;
            end
        end
    end

endmodule

// File: tb/tb_taxi_eth_mac_stat_accum.sv
// Directed bench for the statistics accumulator: a default instance plus a
// narrow 20-bit instance with an ID offset for wrap and range checks.
module tb_taxi_eth_mac_stat_accum;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    taxi_axis_if #(.DATA_W(16), .ID_W(8), .USER_W(1)) stat_if ();
    taxi_axis_if #(.DATA_W(16), .ID_W(8), .USER_W(1)) stat2_if ();

    logic        rd_req_valid, rd_req_ready, rd_req_clr, rd_rsp_valid, init_done;
    logic [7:0]  rd_req_addr;
    logic [63:0] rd_rsp_data;

    logic        rd2_req_valid, rd2_req_ready, rd2_req_clr, rd2_rsp_valid, init2_done;
    logic [3:0]  rd2_req_addr;
    logic [19:0] rd2_rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    taxi_eth_mac_stat_accum #(
        .CNT_W(64), .NUM_CNT(256), .ID_BASE(0), .CLR_ON_RD_EN(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_stat  (stat_if),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_req_clr   (rd_req_clr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .init_done    (init_done)
    );

    taxi_eth_mac_stat_accum #(
        .CNT_W(20), .NUM_CNT(16), .ID_BASE(4), .CLR_ON_RD_EN(0)
    ) dut2 (
        .clk          (clk),
        .rst          (rst),
        .s_axis_stat  (stat2_if),
        .rd_req_valid (rd2_req_valid),
        .rd_req_ready (rd2_req_ready),
        .rd_req_addr  (rd2_req_addr),
        .rd_req_clr   (rd2_req_clr),
        .rd_rsp_valid (rd2_rsp_valid),
        .rd_rsp_data  (rd2_rsp_data),
        .init_done    (init2_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] id, input logic [15:0] inc, input logic user);
        bit acc = 1'b0;
        stat_if.tvalid = 1'b1;
        stat_if.tid    = id;
        stat_if.tdata  = inc;
        stat_if.tuser  = user;
        for (int i = 0; i < 50 && !acc; i++) begin
            #3;
            acc = stat_if.tready;
            @(posedge clk);
            #1;
        end
        stat_if.tvalid = 1'b0;
        if (!acc) chk("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic send2(input logic [7:0] id, input logic [15:0] inc);
        bit acc = 1'b0;
        stat2_if.tvalid = 1'b1;
        stat2_if.tid    = id;
        stat2_if.tdata  = inc;
        stat2_if.tuser  = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            #3;
            acc = stat2_if.tready;
            @(posedge clk);
            #1;
        end
        stat2_if.tvalid = 1'b0;
        if (!acc) chk("send2_timeout", 64'(0), 64'(1));
    endtask

    task automatic rd(input logic [7:0] addr, input logic clr, input logic [63:0] exp, input string tag);
        rd_req_valid = 1'b1;
        rd_req_addr  = addr;
        rd_req_clr   = clr;
        #3;
        chk({tag, "_rdy"}, 64'(rd_req_ready), 64'(1));
        @(posedge clk);
        #1;
        rd_req_valid = 1'b0;
        rd_req_clr   = 1'b0;
        chk({tag, "_early"}, 64'(rd_rsp_valid), 64'(0));
        step();
        chk({tag, "_vld"}, 64'(rd_rsp_valid), 64'(1));
        chk(tag, rd_rsp_data, exp);
    endtask

    task automatic rd2(input logic [3:0] addr, input logic clr, input logic [19:0] exp, input string tag);
        rd2_req_valid = 1'b1;
        rd2_req_addr  = addr;
        rd2_req_clr   = clr;
        @(posedge clk);
        #1;
        rd2_req_valid = 1'b0;
        rd2_req_clr   = 1'b0;
        step();
        chk({tag, "_vld"}, 64'(rd2_rsp_valid), 64'(1));
        chk(tag, 64'(rd2_rsp_data), 64'(exp));
    endtask

    // Counts edges from reset release until init_done; the narrow instance is timed alongside.
    task automatic wait_init(input string tag);
        int n  = 0;
        int n2 = 0;
        while (!init_done && n < 1000) begin
            step();
            n++;
            if (init2_done && n2 == 0) n2 = n;
            if (n == 10) chk({tag, "_sweep_rdy"}, 64'({stat_if.tready, rd_req_ready}), 64'(0));
        end
        chk(tag, 64'(n), 64'(257));
        chk({tag, "_2"}, 64'(n2), 64'(17));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        stat_if.tvalid  = 1'b0; stat_if.tid  = '0; stat_if.tdata  = '0; stat_if.tuser  = '0;
        stat2_if.tvalid = 1'b0; stat2_if.tid = '0; stat2_if.tdata = '0; stat2_if.tuser = '0;
        rd_req_valid  = 1'b0; rd_req_addr  = '0; rd_req_clr  = 1'b0;
        rd2_req_valid = 1'b0; rd2_req_addr = '0; rd2_req_clr = 1'b0;

        repeat (3) step();
        chk("rst_ctl", 64'({stat_if.tready, rd_req_ready, rd_rsp_valid, init_done}), 64'(0));
        chk("rst_data", rd_rsp_data, 64'(0));
        rst = 1'b0;
        wait_init("init_lat");

        for (int a = 0; a < 256; a++) rd(8'(a), 1'b0, 64'(0), "init_zero");

        send(8'd5, 16'd3, 1'b0);
        send(8'd5, 16'd4, 1'b0);
        send(8'd5, 16'd10, 1'b0);
        rd(8'd5, 1'b0, 64'd17, "fwd5");

        send(8'd5, 16'd0, 1'b0);
        rd(8'd5, 1'b0, 64'd17, "zero_inc");

        send(8'd9, 16'd50, 1'b1);
        rd(8'd9, 1'b0, 64'd0, "tuser_drop");

        send(8'd7, 16'd100, 1'b0);
        rd_req_valid = 1'b1;
        rd_req_addr  = 8'd7;
        rd_req_clr   = 1'b1;
        step();
        rd_req_valid   = 1'b0;
        rd_req_clr     = 1'b0;
        stat_if.tvalid = 1'b1;
        stat_if.tid    = 8'd7;
        stat_if.tdata  = 16'd1;
        stat_if.tuser  = 1'b0;
        step();
        stat_if.tvalid = 1'b0;
        chk("clr_rsp_vld", 64'(rd_rsp_valid), 64'(1));
        chk("clr_rsp", rd_rsp_data, 64'd100);
        rd(8'd7, 1'b0, 64'd1, "clr_then_upd");

        fork
            begin
                for (int i = 0; i < 12; i++) send(8'(10 + i % 2), 16'(i * 7 + 1), 1'b0);
            end
            begin
                step();
                step();
                rd_req_valid = 1'b1;
                rd_req_addr  = 8'd20;
                rd_req_clr   = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    #3;
                    chk("bp_tready", 64'(stat_if.tready), 64'(0));
                    @(posedge clk);
                    #1;
                end
                rd_req_valid = 1'b0;
            end
        join
        repeat (3) step();
        rd(8'd10, 1'b0, 64'd216, "bp_sum10");
        rd(8'd11, 1'b0, 64'd258, "bp_sum11");
        rd(8'd20, 1'b0, 64'd0, "bp_rd20");

        for (int k = 0; k < 16; k++) send2(8'd6, 16'hFFFF);
        send2(8'd6, 16'h0020);
        send2(8'd3, 16'd5);
        send2(8'd20, 16'd5);
        rd2(4'd2, 1'b1, 20'h00010, "wrap");
        rd2(4'd2, 1'b0, 20'h00010, "clr_disabled");
        rd2(4'd15, 1'b0, 20'h0, "below_base");
        rd2(4'd0, 1'b0, 20'h0, "above_range");

        stat_if.tvalid = 1'b1;
        stat_if.tid    = 8'd30;
        stat_if.tdata  = 16'd1;
        stat_if.tuser  = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        step();
        stat_if.tvalid = 1'b0;
        chk("rst_mid", 64'({stat_if.tready, rd_req_ready, rd_rsp_valid, init_done}), 64'(0));
        rst = 1'b0;
        wait_init("reinit_lat");
        for (int a = 0; a < 256; a++) rd(8'(a), 1'b0, 64'(0), "post_rst_zero");
        rd2(4'd2, 1'b0, 20'h0, "post_rst2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
